// File: rtl/dram_resp_if.sv
// Engine + host memory port bundle for the DRAM responder.
// Engine side: read request/response and write strobe; host side: preload/readback.
// Status: sticky error flag and saturating access counters.
interface dram_resp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  logic                  dram_en_rd;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  dram_en_wr;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  dram_valid;
  logic                  host_en;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_rvalid;
  logic                  err;
  logic [31:0]           rd_cnt;
  logic [31:0]           wr_cnt;

  modport slave (
    input  dram_en_rd, addr_in, dram_en_wr, addr_out, data_out,
    input  host_en, host_we, host_addr, host_wdata,
    output data_in, dram_valid, host_rdata, host_rvalid, err, rd_cnt, wr_cnt
  );

  modport master (
    output dram_en_rd, addr_in, dram_en_wr, addr_out, data_out,
    output host_en, host_we, host_addr, host_wdata,
    input  data_in, dram_valid, host_rdata, host_rvalid, err, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/dram_resp.sv
// DRAM stand-in: dual-port word memory serving engine reads/writes plus an idle-time host port.
// Latency: engine read data RD_LATENCY cycles after request; host read data 1 cycle after request.
// Backpressure: none; one engine read per cycle accepted, host access ignored on engine collision.
module dram_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int DEPTH      = 65536,
  parameter int RD_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  dram_resp_if.slave   bus
);
  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_oor, wr_oor, host_oor;
  logic                  collide, host_rd_acc, host_wr_acc, wr_do, wr_hit;
  logic [IDX_W-1:0]      rd_idx, wr_idx, host_idx;
  logic [DATA_WIDTH-1:0] rd_word, host_word;

  logic [RD_LATENCY-1:0]                 vld_q, vld_d;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0]                 host_rdata_q, host_rdata_d;
  logic                                  host_rvalid_q, host_rvalid_d;
  logic                                  err_q, err_d;
  logic [31:0]                           rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  // Address decode, range checks and write-first read word selection.
  always_comb begin
    // Range checks use the full address width so high addresses never alias into memory.
    rd_oor   = {1'b0, bus.addr_in}   >= DEPTH_EXT;
    wr_oor   = {1'b0, bus.addr_out}  >= DEPTH_EXT;
    host_oor = {1'b0, bus.host_addr} >= DEPTH_EXT;
    rd_idx   = bus.addr_in[IDX_W-1:0];
    wr_idx   = bus.addr_out[IDX_W-1:0];
    host_idx = bus.host_addr[IDX_W-1:0];

    collide     = bus.host_en && (bus.dram_en_rd || bus.dram_en_wr);
    host_rd_acc = bus.host_en && !bus.host_we && !collide;
    host_wr_acc = bus.host_en &&  bus.host_we && !collide;
    wr_do       = bus.dram_en_wr && !wr_oor;
    // A same-edge write to the read address is forwarded so the read sees the new word.
    wr_hit      = wr_do && (bus.addr_out == bus.addr_in);

    rd_word = '0;
    if (!rd_oor) rd_word = wr_hit ? bus.data_out : mem[rd_idx];
    host_word = host_oor ? '0 : mem[host_idx];
  end

  // Next-state for the read pipeline, host read port, error flag and counters.
  always_comb begin
    // Each stage only reloads data behind a valid, so the output word holds between responses.
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = bus.dram_en_rd;
    if (bus.dram_en_rd) dat_d[0] = rd_word;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end

    host_rvalid_d = host_rd_acc;
    host_rdata_d  = host_rd_acc ? host_word : host_rdata_q;

    err_d = err_q
          | (bus.dram_en_rd && rd_oor)
          | (bus.dram_en_wr && wr_oor)
          | collide
          | (bus.host_en && !collide && host_oor);

    rd_cnt_d = rd_cnt_q + ((bus.dram_en_rd && (rd_cnt_q != '1)) ? 32'd1 : 32'd0);
    wr_cnt_d = wr_cnt_q + ((bus.dram_en_wr && (wr_cnt_q != '1)) ? 32'd1 : 32'd0);
  end

  // State registers; reset drops in-flight reads but leaves memory untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q         <= '0;
      dat_q         <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      err_q         <= 1'b0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
    end else begin
      vld_q         <= vld_d;
      dat_q         <= dat_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      err_q         <= err_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  // Memory array update: engine write, else an accepted in-range host write.
  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[wr_idx] <= bus.data_out;
    end else if (host_wr_acc && !host_oor) begin
      mem[host_idx] <= bus.host_wdata;
    end
  end

  assign bus.data_in     = dat_q[RD_LATENCY-1];
  assign bus.dram_valid  = vld_q[RD_LATENCY-1];
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.err         = err_q;
  assign bus.rd_cnt      = rd_cnt_q;
  assign bus.wr_cnt      = wr_cnt_q;
endmodule

// File: tb/tb_dram_resp.sv
// Scoreboard bench for dram_resp: directed engine/host traffic with hand-computed responses.
// Expected read data and arrival cycle are queued at issue; a negedge monitor pops on each valid.
// Status outputs (err, counters, held data) are checked directly at quiet points.
module tb_dram_resp;
  localparam int DW  = 32;
  localparam int AW  = 18;
  localparam int RDL = 2;

  typedef struct {
    logic [DW-1:0] dat;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t eng_q[$];
  exp_t host_q[$];

  dram_resp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dram_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(65536), .RD_LATENCY(RDL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid must match the head of its queue, in data and arrival cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_q.size() > 0 && eng_q[0].due < cyc) begin
        checks++; failures++;
        $display("FAIL eng_missing want data=%h at cyc=%0d now cyc=%0d", eng_q[0].dat, eng_q[0].due, cyc);
        void'(eng_q.pop_front());
      end
      if (host_q.size() > 0 && host_q[0].due < cyc) begin
        checks++; failures++;
        $display("FAIL host_missing want data=%h at cyc=%0d now cyc=%0d", host_q[0].dat, host_q[0].due, cyc);
        void'(host_q.pop_front());
      end
      if (bus.dram_valid) begin
        checks++;
        if (eng_q.size() == 0) begin
          failures++;
          $display("FAIL eng_unexpected got data=%h at cyc=%0d, want no valid", bus.data_in, cyc);
        end else begin
          exp_t e;
          e = eng_q.pop_front();
          if (bus.data_in !== e.dat || cyc != e.due) begin
            failures++;
            $display("FAIL eng_rd got data=%h cyc=%0d, want data=%h cyc=%0d", bus.data_in, cyc, e.dat, e.due);
          end
        end
      end
      if (bus.host_rvalid) begin
        checks++;
        if (host_q.size() == 0) begin
          failures++;
          $display("FAIL host_unexpected got data=%h at cyc=%0d, want no valid", bus.host_rdata, cyc);
        end else begin
          exp_t e;
          e = host_q.pop_front();
          if (bus.host_rdata !== e.dat || cyc != e.due) begin
            failures++;
            $display("FAIL host_rd got data=%h cyc=%0d, want data=%h cyc=%0d", bus.host_rdata, cyc, e.dat, e.due);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, entered and left just after a rising edge.
  task automatic drive(input bit rd, input logic [AW-1:0] ra, input bit push, input logic [DW-1:0] rexp,
                       input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit hen, input bit hwe, input logic [AW-1:0] ha,
                       input logic [DW-1:0] hwd, input bit hpush, input logic [DW-1:0] hexp);
    bus.dram_en_rd = rd;  bus.addr_in = ra;
    bus.dram_en_wr = wr;  bus.addr_out = wa;  bus.data_out = wd;
    bus.host_en = hen;    bus.host_we = hwe;  bus.host_addr = ha;  bus.host_wdata = hwd;
    if (rd && push) eng_q.push_back('{rexp, cyc + RDL});
    if (hpush)      host_q.push_back('{hexp, cyc + 1});
    @(posedge clk); #1;
    bus.dram_en_rd = 1'b0; bus.dram_en_wr = 1'b0; bus.host_en = 1'b0; bus.host_we = 1'b0;
  endtask

  task automatic eng_rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    drive(1, a, 1, e, 0, '0, '0, 0, 0, '0, '0, 0, '0);
  endtask
  task automatic eng_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(0, '0, 0, '0, 1, a, d, 0, 0, '0, '0, 0, '0);
  endtask
  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(0, '0, 0, '0, 0, '0, '0, 1, 1, a, d, 0, '0);
  endtask
  task automatic host_rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    drive(0, '0, 0, '0, 0, '0, '0, 1, 0, a, '0, 1, e);
  endtask

  // Wait (bounded) for all queued responses to be consumed by the monitor.
  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (eng_q.size() == 0 && host_q.size() == 0) break;
      @(posedge clk); #1;
    end
    checks++;
    if (eng_q.size() != 0 || host_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s got pending eng=%0d host=%0d want 0", name, eng_q.size(), host_q.size());
      eng_q.delete(); host_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.dram_en_rd = 0; bus.addr_in = '0; bus.dram_en_wr = 0; bus.addr_out = '0; bus.data_out = '0;
    bus.host_en = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dram_valid", {31'd0, bus.dram_valid}, 32'd0);
    chk("rst_data_in", bus.data_in, 32'd0);
    chk("rst_host_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
    chk("rst_host_rdata", bus.host_rdata, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_rd_cnt", bus.rd_cnt, 32'd0);
    chk("rst_wr_cnt", bus.wr_cnt, 32'd0);
    @(posedge clk); #1;

    // Single read with fixed latency, then held output.
    host_wr(18'd5, 32'h0001_0000);
    eng_rd(18'd5, 32'h0001_0000);
    drain("single");
    @(negedge clk);
    chk("hold_valid", {31'd0, bus.dram_valid}, 32'd0);
    chk("hold_data_in", bus.data_in, 32'h0001_0000);
    chk("rd_cnt_one", bus.rd_cnt, 32'd1);
    @(posedge clk); #1;

    // Back-to-back reads after preload.
    for (int i = 0; i < 4; i++) host_wr(AW'(i), 32'(10 + i));
    for (int i = 0; i < 4; i++) eng_rd(AW'(i), 32'(10 + i));
    drain("burst");

    // Same-edge read and write to one address returns the new word.
    drive(1, 18'd7, 1, 32'hDEAD_BEEF, 1, 18'd7, 32'hDEAD_BEEF, 0, 0, '0, '0, 0, '0);
    // Read snapshot is unaffected by a following write.
    host_wr(18'd9, 32'd3);
    eng_rd(18'd9, 32'd3);
    eng_wr(18'd9, 32'd99);
    eng_rd(18'd9, 32'd99);
    // Dual-port: read 0 while writing 1.
    drive(1, 18'd0, 1, 32'd10, 1, 18'd1, 32'd55, 0, 0, '0, '0, 0, '0);
    eng_rd(18'd1, 32'd55);
    host_rd(18'd9, 32'd99);
    drain("hazard");
    @(negedge clk);
    chk("err_clean", {31'd0, bus.err}, 32'd0);
    @(posedge clk); #1;

    // Out of range: 70000 must not alias onto 70000-65536=4464.
    host_wr(18'd4464, 32'h0000_1234);
    eng_rd(18'd70000, 32'd0);
    eng_wr(18'd70000, 32'h0000_0BAD);
    host_rd(18'd4464, 32'h0000_1234);
    drain("oor");
    @(negedge clk);
    chk("err_oor", {31'd0, bus.err}, 32'd1);
    chk("rd_cnt_total", bus.rd_cnt, 32'd11);
    chk("wr_cnt_total", bus.wr_cnt, 32'd4);
    @(posedge clk); #1;

    // Reset with reads in flight: nothing may come out afterwards.
    drive(1, 18'd5, 0, '0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
    drive(1, 18'd6, 0, '0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, bus.dram_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_rst_rd_cnt", bus.rd_cnt, 32'd0);
    chk("post_rst_wr_cnt", bus.wr_cnt, 32'd0);
    chk("post_rst_err", {31'd0, bus.err}, 32'd0);
    @(posedge clk); #1;
    host_rd(18'd5, 32'h0001_0000);
    drain("post_rst");

    // Host/engine collision: host write ignored, engine read served, err set.
    drive(1, 18'd0, 1, 32'd10, 0, '0, '0, 1, 1, 18'd3, 32'h0000_FFFF, 0, '0);
    host_rd(18'd3, 32'd13);
    host_rd(18'd70000, 32'd0);
    drain("collide");
    @(negedge clk);
    chk("err_collide", {31'd0, bus.err}, 32'd1);
    chk("rd_cnt_collide", bus.rd_cnt, 32'd1);
    chk("wr_cnt_collide", bus.wr_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_resp.md
Name: dram_resp

Overview:
- DRAM-side responder for the convolution engine's memory port. Serves the engine's read requests (dram_en_rd/addr_in) with data_in plus dram_valid after a fixed latency, and commits its writes (dram_en_wr/addr_out/data_out).
- Stands in for external DRAM at the top level and in block benches.
- A host port preloads kernels and ifmaps and reads back ofmaps while the engine is idle.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 18, address width.
- DEPTH, 65536, implemented words. Addresses >= DEPTH are out of range.
- RD_LATENCY, 2, cycles from read request to dram_valid. Legal range 1..4.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- dram_en_rd  input  1  engine read request, one per cycle.
- addr_in  input  ADDR_WIDTH  engine read address.
- dram_en_wr  input  1  engine write strobe.
- addr_out  input  ADDR_WIDTH  engine write address.
- data_out  input  DATA_WIDTH  engine write data.
- data_in  output  DATA_WIDTH  read data returned to engine.
- dram_valid  output  1  data_in valid this cycle.
- host_en  input  1  host access strobe.
- host_we  input  1  host access is a write (meaningful with host_en).
- host_addr  input  ADDR_WIDTH  host address.
- host_wdata  input  DATA_WIDTH  host write data.
- host_rdata  output  DATA_WIDTH  host read data.
- host_rvalid  output  1  host_rdata valid.
- err  output  1  sticky error flag.
- rd_cnt  output  32  accepted engine reads.
- wr_cnt  output  32  accepted engine writes.

Behaviour:
- Reset (async assert, sync release): data_in=0, dram_valid=0, host_rdata=0, host_rvalid=0, err=0, rd_cnt=0, wr_cnt=0. All latency-pipeline valids are cleared. Memory contents are NOT reset.
- Reset mid-operation: in-flight reads are discarded and no dram_valid is produced for them.
- Engine read: the request is sampled on the rising edge where dram_en_rd=1. The word is read from memory state at that edge, then delayed through an RD_LATENCY-stage pipeline. dram_valid=1 and data_in=word exactly RD_LATENCY cycles later, for one cycle.
- Engine read pipelining: back-to-back reads every cycle are supported with no bubbles, giving up to RD_LATENCY requests in flight.
- data_in when dram_valid=0: holds its last value.
- Engine write: mem[addr_out] <= data_out on an edge with dram_en_wr=1.
- Same-edge read and write to the same address: write-first. The read returns the new data_out value.
- Read and write to different addresses in the same cycle: both proceed (dual-port).
- Read hazard: a write landing while an earlier read is in flight does not alter that read's returned data (snapshot at request).
- Out of range (address >= DEPTH): the read returns 0 (still with dram_valid) and the write is dropped. Either case sets err=1 until rst.
- Host port: host_en=1 with host_we=1 writes host_wdata. host_en=1 with host_we=0 returns host_rdata with host_rvalid=1 on the next cycle (latency 1, fixed).
- Host vs engine collision: a host access in the same cycle as any engine dram_en_rd or dram_en_wr is a protocol violation. The host access is ignored, the engine access proceeds, and err is set.
- Host out-of-range: a read returns 0 and a write is dropped; both set err.
- Counters: rd_cnt increments on each accepted engine read and wr_cnt on each accepted engine write, including out-of-range ones. Both saturate at 32'hFFFF_FFFF. Host accesses are not counted.
- Width rule: the address is compared against DEPTH using the full ADDR_WIDTH bits, with no truncation or wrap-around.

Test Plan:
- Host writes mem[5]=32'h0001_0000, then the engine reads 5 → dram_valid high exactly 2 cycles after the request, data_in=32'h0001_0000, rd_cnt=1.
- Engine reads addresses 0,1,2,3 on consecutive cycles after host preload of values 10,11,12,13 → dram_valid high for 4 consecutive cycles with data 10,11,12,13.
- Same-cycle engine read and write of addr 7 with data_out=32'hDEAD_BEEF → read returns 32'hDEAD_BEEF.
- Read addr 9 (value 3), then write addr 9=99 one cycle later → returned data is 3, and a subsequent read returns 99.
- Engine read of addr 70000 with DEPTH=65536 → data_in=0 with dram_valid=1, err=1. A later write to 70000 leaves memory unchanged.
- Assert rst with 2 reads in flight → no dram_valid after deassert, counters=0, err=0, and mem[5] still reads 32'h0001_0000.
